// File: rtl/sdram_arbiter.sv
// sdram_arbiter: three-port arbiter (CPU r/w, sprite burst, fix-layer read) in front of one SDRAM controller.
// p2 is promoted to top priority after STARVE_LIMIT consecutive lost arbitrations.
module sdram_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [24:0] p0_addr,
  input  logic [15:0] p0_din,
  input  logic [1:0]  p0_wtbt,
  output logic [15:0] p0_dout,
  output logic        p0_ack,
  input  logic        p1_req,
  input  logic [24:0] p1_addr,
  output logic [63:0] p1_dout,
  output logic        p1_ack,
  input  logic        p2_req,
  input  logic [24:0] p2_addr,
  output logic [15:0] p2_dout,
  output logic        p2_ack,
  output logic [24:0] sd_addr,
  output logic [15:0] sd_din,
  output logic [1:0]  sd_wtbt,
  output logic        sd_we,
  output logic        sd_rd,
  output logic        sd_rd_type,
  input  logic [63:0] sd_dout,
  input  logic        sd_ready,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  state_t state, next;
  logic [1:0] sel, gnt;
  logic [CW-1:0] starve_cnt;
  logic any, wr_sel, wr;
  always_comb begin
    any = p0_req | p1_req | p2_req;
    sel = (p2_req && (starve_cnt >= LIM || !(p0_req || p1_req))) ? 2'd2 : p1_req ? 2'd1 : 2'd0;
    wr_sel = sel == 2'd0 && p0_we;
    busy = state != IDLE;
    next = state;
    case (state)
      IDLE:    next = any ? ISSUE : IDLE;
      ISSUE:   next = WAIT;
      WAIT:    next = sd_ready ? DONE : WAIT;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= next;
  end
  // strobes and acks default low so each is a single-cycle pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt <= 2'd0;
      wr <= 1'b0;
      starve_cnt <= '0;
      sd_addr <= '0;
      sd_din <= '0;
      sd_wtbt <= '0;
      sd_rd <= 1'b0;
      sd_we <= 1'b0;
      sd_rd_type <= 1'b0;
      p0_dout <= '0;
      p1_dout <= '0;
      p2_dout <= '0;
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      p2_ack <= 1'b0;
    end else begin
      sd_rd <= 1'b0;
      sd_we <= 1'b0;
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      p2_ack <= 1'b0;
      if (state == IDLE && any) begin
        gnt <= sel;
        wr <= wr_sel;
        sd_addr <= sel == 2'd1 ? p1_addr : sel == 2'd2 ? p2_addr : p0_addr;
        sd_din <= wr_sel ? p0_din : '0;
        sd_wtbt <= wr_sel ? p0_wtbt : 2'b00;
        sd_rd_type <= sel == 2'd1;
        sd_rd <= !wr_sel;
        sd_we <= wr_sel;
        if (sel == 2'd2) starve_cnt <= '0;
        else if (p2_req && starve_cnt < LIM) starve_cnt <= starve_cnt + 1'b1;
      end
      if (state == WAIT && sd_ready) begin
        p0_ack <= gnt == 2'd0;
        p1_ack <= gnt == 2'd1;
        p2_ack <= gnt == 2'd2;
        if (gnt == 2'd1) p1_dout <= sd_dout;
        if (gnt == 2'd2) p2_dout <= sd_dout[63:48];
        if (gnt == 2'd0 && !wr) p0_dout <= sd_dout[63:48];
      end
    end
  end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: expected controller transactions and acks are queued as stimulus is driven;
// a controller model pops them on each strobe and an ack monitor pops them on each completion.
module tb_sdram_arbiter;
  logic clk = 1'b0, reset;
  logic p0_req, p0_we, p0_ack, p1_req, p1_ack, p2_req, p2_ack;
  logic [24:0] p0_addr, p1_addr, p2_addr, sd_addr;
  logic [15:0] p0_din, p0_dout, p2_dout, sd_din;
  logic [1:0] p0_wtbt, sd_wtbt;
  logic [63:0] p1_dout, sd_dout;
  logic sd_we, sd_rd, sd_rd_type, sd_ready, busy;

  typedef struct {int port; logic we; logic [24:0] addr; logic [15:0] din; logic [1:0] wtbt;
                  logic [63:0] rdata; int lat; logic [63:0] exp;} vec_t;
  typedef struct {int port; logic [63:0] data;} ack_t;
  vec_t tbl[7];
  vec_t iq[$];
  ack_t aq[$];
  int checks = 0, passes = 0, n_issue = 0, exp_acks = 0, ack_seen = 0, strobes = 0;
  int rep[3] = '{0, 0, 0};

  sdram_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_din(p0_din), .p0_wtbt(p0_wtbt),
    .p0_dout(p0_dout), .p0_ack(p0_ack),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_dout(p1_dout), .p1_ack(p1_ack),
    .p2_req(p2_req), .p2_addr(p2_addr), .p2_dout(p2_dout), .p2_ack(p2_ack),
    .sd_addr(sd_addr), .sd_din(sd_din), .sd_wtbt(sd_wtbt), .sd_we(sd_we), .sd_rd(sd_rd),
    .sd_rd_type(sd_rd_type), .sd_dout(sd_dout), .sd_ready(sd_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, {60'd0, sd_rd, sd_we, sd_rd_type, busy}, 64'd0);
    chk({tag, "_acks"}, {61'd0, p0_ack, p1_ack, p2_ack}, 64'd0);
    chk({tag, "_sd_addr"}, {39'd0, sd_addr}, 64'd0);
    chk({tag, "_sd_din_wtbt"}, {46'd0, sd_din, sd_wtbt}, 64'd0);
    chk({tag, "_p0_dout"}, {48'd0, p0_dout}, 64'd0);
    chk({tag, "_p1_dout"}, p1_dout, 64'd0);
    chk({tag, "_p2_dout"}, {48'd0, p2_dout}, 64'd0);
  endtask

  task automatic push(input vec_t v, input bit ack);
    ack_t a;
    iq.push_back(v);
    n_issue++;
    if (ack) begin
      a.port = v.port;
      a.data = v.exp;
      aq.push_back(a);
      exp_acks++;
    end
  endtask

  task automatic set_port(input vec_t v);
    if (v.port == 0) begin
      p0_we = v.we; p0_addr = v.addr; p0_din = v.din; p0_wtbt = v.wtbt; p0_req = 1'b1;
    end else if (v.port == 1) begin
      p1_addr = v.addr; p1_req = 1'b1;
    end else begin
      p2_addr = v.addr; p2_req = 1'b1;
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (ack_seen < exp_acks && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(ack_seen), 64'(exp_acks));
  endtask

  // controller model: checks each strobe against the next queued transaction, then answers it
  initial begin
    vec_t r;
    int cnt = 0;
    logic prev = 1'b0;
    sd_ready = 1'b1;
    sd_dout = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cnt = 0; sd_ready = 1'b1; prev = 1'b0;
      end else if (sd_rd || sd_we) begin
        strobes++;
        chk("strobe_width", {63'd0, prev}, 64'd0);
        if (iq.size() == 0) chk("unexpected_strobe", 64'(iq.size()), 64'd1);
        else begin
          r = iq.pop_front();
          chk("sd_addr", {39'd0, sd_addr}, {39'd0, r.addr});
          chk("sd_we", {63'd0, sd_we}, {63'd0, r.we});
          chk("sd_rd", {63'd0, sd_rd}, {63'd0, !r.we});
          chk("sd_rd_type", {63'd0, sd_rd_type}, {63'd0, r.port == 1});
          chk("sd_wtbt", {62'd0, sd_wtbt}, {62'd0, r.we ? r.wtbt : 2'b00});
          if (r.we) chk("sd_din", {48'd0, sd_din}, {48'd0, r.din});
          sd_dout = r.rdata;
          cnt = r.lat;
          sd_ready = r.lat == 0;
        end
        prev = 1'b1;
      end else begin
        prev = 1'b0;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) sd_ready = 1'b1;
        end
      end
    end
  end

  // ack monitor: requesters drop req on the ack unless a repeat count keeps them asking
  initial begin
    ack_t a;
    int n, p;
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      n = int'(p0_ack) + int'(p1_ack) + int'(p2_ack);
      if (!reset && n != 0) begin
        p = p1_ack ? 1 : p2_ack ? 2 : 0;
        ack_seen++;
        chk("ack_onehot", 64'(n), 64'd1);
        chk("ack_width", {63'd0, prev}, 64'd0);
        if (aq.size() == 0) chk("unexpected_ack", 64'(aq.size()), 64'd1);
        else begin
          a = aq.pop_front();
          chk("ack_port", 64'(p), 64'(a.port));
          chk("ack_dout", p == 1 ? p1_dout : p == 2 ? {48'd0, p2_dout} : {48'd0, p0_dout}, a.data);
        end
        if (rep[p] > 0) rep[p]--;
        else if (p == 0) p0_req = 1'b0;
        else if (p == 1) p1_req = 1'b0;
        else p2_req = 1'b0;
      end
      prev = n != 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v, v0, v2;
    tbl[0] = '{0, 1'b0, 25'h0000100, 16'h0000, 2'b11, 64'hBEEF_1111_2222_3333, 10, 64'hBEEF};
    tbl[1] = '{0, 1'b1, 25'h0000200, 16'h1234, 2'b11, 64'hDEAD_0000_0000_0000, 3, 64'hBEEF};
    tbl[2] = '{1, 1'b0, 25'h0000400, 16'h0000, 2'b00, 64'h0123_4567_89AB_CDEF, 5, 64'h0123_4567_89AB_CDEF};
    tbl[3] = '{2, 1'b0, 25'h1FFFFFE, 16'h0000, 2'b00, 64'hCAFE_0000_0000_0001, 0, 64'hCAFE};
    tbl[4] = '{0, 1'b0, 25'h1FFFFFF, 16'h0000, 2'b01, 64'h5A5A_FFFF_FFFF_FFFF, 1, 64'h5A5A};
    tbl[5] = '{0, 1'b1, 25'h0000000, 16'hFFFF, 2'b01, 64'h0000_0000_0000_0000, 0, 64'h5A5A};
    tbl[6] = '{1, 1'b0, 25'h1FFFFF8, 16'h0000, 2'b00, 64'hFEDC_BA98_7654_3210, 0, 64'hFEDC_BA98_7654_3210};
    reset = 1'b1;
    {p0_req, p0_we, p1_req, p2_req} = '0;
    {p0_addr, p1_addr, p2_addr} = '0;
    p0_din = '0;
    p0_wtbt = '0;
    #1 chk_zero("reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      push(tbl[i], 1'b1);
      @(negedge clk);
      set_port(tbl[i]);
      wait_done($sformatf("row%0d_done", i));
    end
    // hit case: ready never drops, ack exactly three cycles after the grant cycle
    v = '{2, 1'b0, 25'h0000123, 16'h0, 2'b00, 64'h7777_0000_0000_0000, 0, 64'h7777};
    push(v, 1'b1);
    @(negedge clk);
    set_port(v);
    @(negedge clk);
    chk("lat_issue_busy", {62'd0, busy, sd_rd}, 64'd3);
    @(negedge clk);
    chk("lat_wait_noack", {63'd0, p2_ack}, 64'd0);
    @(negedge clk);
    chk("lat_ack", {63'd0, p2_ack}, 64'd1);
    chk("lat_dout", {48'd0, p2_dout}, 64'h7777);
    wait_done("lat_done");
    // simultaneous requests: p1, then p0, then p2
    v = '{1, 1'b0, 25'h0001000, 16'h0, 2'b00, 64'h1111_2222_3333_4444, 2, 64'h1111_2222_3333_4444};
    v0 = '{0, 1'b0, 25'h0002000, 16'h0, 2'b10, 64'h4444_0000_0000_0000, 2, 64'h4444};
    v2 = '{2, 1'b0, 25'h0003000, 16'h0, 2'b00, 64'h9999_0000_0000_0000, 2, 64'h9999};
    push(v, 1'b1);
    push(v0, 1'b1);
    push(v2, 1'b1);
    @(negedge clk);
    set_port(v2);
    set_port(v0);
    set_port(v);
    wait_done("prio_done");
    // starvation: p1 keeps asking, p2 must win the ninth arbitration
    rep[1] = 8;
    for (int i = 0; i < 8; i++) begin
      v = '{1, 1'b0, 25'h0004000, 16'h0, 2'b00, {16'h1000 + 16'(i), 48'hABC}, 1, {16'h1000 + 16'(i), 48'hABC}};
      push(v, 1'b1);
    end
    v2 = '{2, 1'b0, 25'h00000A0, 16'h0, 2'b00, 64'h2222_0000_0000_0000, 2, 64'h2222};
    push(v2, 1'b1);
    v = '{1, 1'b0, 25'h0004000, 16'h0, 2'b00, 64'h3333_0000_0000_0005, 0, 64'h3333_0000_0000_0005};
    push(v, 1'b1);
    v0 = '{0, 1'b0, 25'h0005000, 16'h0, 2'b00, 64'h0F0F_0000_0000_0000, 0, 64'h0F0F};
    push(v0, 1'b1);
    @(negedge clk);
    set_port(v);
    set_port(v0);
    set_port(v2);
    wait_done("starve_done");
    chk("starve_clear", 64'(dut.starve_cnt), 64'd0);
    // reset during the WAIT of a p1 burst abandons it
    v = '{1, 1'b0, 25'h0006000, 16'h0, 2'b00, 64'h6666_0000_0000_0000, 20, 64'h0};
    push(v, 1'b0);
    @(negedge clk);
    set_port(v);
    repeat (2) @(negedge clk);
    chk("abort_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    p1_req = 1'b0;
    #1 chk_zero("abort");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    v = '{1, 1'b0, 25'h0007000, 16'h0, 2'b00, 64'h8888_7777_6666_5555, 3, 64'h8888_7777_6666_5555};
    push(v, 1'b1);
    @(negedge clk);
    set_port(v);
    wait_done("after_reset_done");
    repeat (4) @(negedge clk);
    chk("issue_q_empty", 64'(iq.size()), 64'd0);
    chk("ack_q_empty", 64'(aq.size()), 64'd0);
    chk("strobe_count", 64'(strobes), 64'(n_issue));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 8, number of consecutive lost arbitrations after which port 2 is promoted to top priority.
REQ-002 clk  in  1  system clock, same clock as the SDRAM controller; all logic is rising-edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 p0_req  in  1  CPU port request; held high until p0_ack.
REQ-005 p0_we  in  1  CPU port: 1=write, 0=single-word read.
REQ-006 p0_addr  in  25  CPU port byte address.
REQ-007 p0_din  in  16  CPU port write data.
REQ-008 p0_wtbt  in  2  CPU port byte enables, passed unchanged to the controller.
REQ-009 p0_dout  out  16  CPU port read data.
REQ-010 p0_ack  out  1  one-cycle completion pulse for the CPU port.
REQ-011 p1_req  in  1  sprite port request: 4-word burst read, held until p1_ack.
REQ-012 p1_addr  in  25  sprite port address.
REQ-013 p1_dout  out  64  sprite burst data; word0 is in [63:48].
REQ-014 p1_ack  out  1  one-cycle completion pulse for the sprite port.
REQ-015 p2_req, p2_addr, p2_dout, p2_ack  in/in/out/out  1/25/16/1  fix-layer single-read port; semantics match port 0 reads.
REQ-016 sd_addr  out  25  controller address.
REQ-017 sd_din  out  16  controller write data.
REQ-018 sd_wtbt  out  2  controller byte enables.
REQ-019 sd_we  out  1  controller write strobe; the controller acts on its rising edge.
REQ-020 sd_rd  out  1  controller read strobe; the controller acts on its rising edge.
REQ-021 sd_rd_type  out  1  controller read type: 0=single, 1=4-word burst.
REQ-022 sd_dout  in  64  controller read data.
REQ-023 sd_ready  in  1  controller ready: low while busy, high when done.
REQ-024 busy  out  1  high in every state except IDLE.

Function
REQ-025 FSM states: IDLE, ISSUE, WAIT, DONE. Exactly one transaction is outstanding at a time.
REQ-026 IDLE, with at least one request pending:
- select the grant, register sd_addr, sd_din, sd_wtbt and sd_rd_type;
- set sd_rd=1, or sd_we=1 for a p0 write;
- go to ISSUE.
REQ-027 Priority: p1 > p0 > p2, except that p2 is ranked first while starve_cnt >= STARVE_LIMIT.
REQ-028 starve_cnt:
- increments, saturating at STARVE_LIMIT, each time a grant is issued to another port while p2_req is high;
- clears when p2 is granted.
REQ-029 ISSUE: drive sd_rd=0 and sd_we=0, then go to WAIT. Each strobe is therefore high for exactly one cycle, with at least two low cycles between strobes.
REQ-030 WAIT: when sd_ready=1, go to DONE and, on the same edge:
- capture read data: p1 takes all 64 bits; p0/p2 take sd_dout[63:48];
- raise the granted port's ack.
Otherwise remain in WAIT.
REQ-031 sd_ready high in the first WAIT cycle (controller same-address hit, ready never drops) is a valid completion. No minimum wait is enforced beyond ISSUE.
REQ-032 DONE: ack is high for exactly this one cycle; clear it and return to IDLE.
REQ-033 Ack latency when the controller reports ready immediately: 3 cycles from the IDLE grant cycle.
REQ-034 Requesters drop req on the edge where they sample ack. The arbiter SHALL NOT re-grant the same port in the IDLE cycle immediately following DONE unless its req is still high.
REQ-035 pN_dout holds its value until that port's next read completes. p0 writes do not modify p0_dout.
REQ-036 sd_rd_type is 1 only for p1 grants. sd_wtbt is 2'b00 for all reads.
REQ-037 Requests arriving while busy are not lost; they are arbitrated at the next IDLE cycle.
REQ-038 Priority is evaluated only in IDLE. A grant is never revoked by a later higher-priority request.

Reset
REQ-039 While reset is high, asynchronously:
- state = IDLE;
- sd_rd, sd_we, sd_rd_type, all acks, busy = 0;
- sd_addr, sd_din, sd_wtbt, all dout = 0;
- starve_cnt = 0.
REQ-040 Reset mid-transaction abandons it: no ack is issued for the in-flight request, and the strobe is forced low.
REQ-041 Operation resumes on the first clk edge after reset deasserts, with no extra synchronisation cycles.

Verification
REQ-042 p0 read of 0x000100, sd_ready drops for 10 cycles, sd_dout[63:48]=0xBEEF -> exactly one sd_rd pulse, p0_dout=0xBEEF, one p0_ack pulse.
REQ-043 p0 write of 0x1234 to 0x000200, wtbt=2'b11 -> sd_we pulse, sd_din=0x1234, sd_wtbt=2'b11, p0_ack; p0_dout unchanged.
REQ-044 p0, p1 and p2 requests raised in the same cycle -> grant order p1 (sd_rd_type=1, 64-bit data), then p0, then p2.
REQ-045 p1 and p0 request continuously while p2 is held high -> p2 is granted after at most 8 other grants; starve_cnt then returns to 0.
REQ-046 sd_ready held high throughout (hit case) -> ack 3 cycles after the grant; dout equals current sd_dout.
REQ-047 reset asserted during WAIT of a p1 burst -> no p1_ack; all outputs 0; a fresh p1 request after release completes normally.
